// File: rtl/sp_fill_scheduler.sv
// Fills the input-feature and filter scratchpads from one shared single-port
// source memory, alternating read beats between the two streams.
module sp_fill_scheduler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] if_base,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [ADDR_W-1:0] flt_base,
  input  logic [LEN_W-1:0]  flt_len,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              if_full,
  input  logic              flt_full,
  output logic              if_wen,
  output logic [DATA_W-1:0] if_wdata,
  output logic              flt_wen,
  output logic [DATA_W-1:0] flt_wdata,
  output logic              done1,
  output logic              done2,
  output logic              busy,
  output logic              abort
);
  // One register stage between read issue and scratchpad write.
  localparam int   STAGES = 1;
  localparam logic S_IF   = 1'b0;
  localparam logic S_FLT  = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic strm;
    logic last;
  } tag_t;

  state_t                  state;
  logic [1:0][ADDR_W-1:0]  base_q;
  logic [1:0][LEN_W-1:0]   len_q;
  logic [1:0][LEN_W-1:0]   cnt_q;
  logic [1:0]              done_q;
  logic                    ptr;
  logic [STAGES:0]         vld_pipe;
  tag_t [STAGES:0]         tag_pipe;
  logic [ADDR_W-1:0]       addr_q;
  logic                    abort_q;

  logic [1:0]              pend;
  logic                    gnt_vld, gnt_s, blocked, fire, gnt_last;
  logic [LEN_W-1:0]        cnt_nxt;

  always_comb begin
    pend[0]  = cnt_q[0] < len_q[0];
    pend[1]  = cnt_q[1] < len_q[1];
    gnt_vld  = (state == ISSUE) && (|pend);
    gnt_s    = (&pend) ? ptr : pend[1];
    blocked  = gnt_vld && (gnt_s ? flt_full : if_full);
    fire     = gnt_vld && !blocked;
    cnt_nxt  = cnt_q[gnt_s] + LEN_W'(1);
    gnt_last = (cnt_nxt == len_q[gnt_s]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      ptr      <= S_IF;
      vld_pipe <= '0;
      tag_pipe <= '0;
      addr_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      vld_pipe[0] <= fire;
      tag_pipe[0] <= '{strm: gnt_s, last: gnt_last};
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      abort_q <= blocked;

      if (fire) begin
        addr_q       <= base_q[gnt_s] + ADDR_W'(cnt_q[gnt_s]);
        cnt_q[gnt_s] <= cnt_nxt;
        ptr          <= ~ptr;
      end

      // Completion follows the landing write, so it is independent of FSM state.
      if (vld_pipe[STAGES] && tag_pipe[STAGES].last)
        done_q[tag_pipe[STAGES].strm] <= 1'b1;

      case (state)
        IDLE: if (start) begin
          base_q <= {flt_base, if_base};
          len_q  <= {flt_len, if_len};
          cnt_q  <= '0;
          ptr    <= S_IF;
          done_q <= {flt_len == '0, if_len == '0};
          state  <= ISSUE;
        end
        ISSUE: begin
          if (blocked)     state <= IDLE;
          else if (~|pend) state <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ren   = vld_pipe[0];
  assign mem_addr  = addr_q;
  assign if_wen    = vld_pipe[STAGES] && (tag_pipe[STAGES].strm == S_IF);
  assign flt_wen   = vld_pipe[STAGES] && (tag_pipe[STAGES].strm == S_FLT);
  assign if_wdata  = if_wen  ? mem_rdata : '0;
  assign flt_wdata = flt_wen ? mem_rdata : '0;
  assign done1     = done_q[0];
  assign done2     = done_q[1];
  assign busy      = (state != IDLE);
  assign abort     = abort_q;

endmodule

// File: tb/tb_sp_fill_scheduler.sv
// Randomized scoreboard bench for sp_fill_scheduler against a list-based fill model.
module tb_sp_fill_scheduler;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] if_base = '0, flt_base = '0;
  logic [LW-1:0] if_len = '0, flt_len = '0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_full = 1'b0, flt_full = 1'b0;
  logic          if_wen, flt_wen;
  logic [DW-1:0] if_wdata, flt_wdata;
  logic          done1, done2, busy, abort;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          strm;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t rd_q[$];
  beat_t wr_q[$];

  always #5 clk = ~clk;

  sp_fill_scheduler #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .if_base(if_base), .if_len(if_len), .flt_base(flt_base), .flt_len(flt_len),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .if_full(if_full), .flt_full(flt_full),
    .if_wen(if_wen), .if_wdata(if_wdata), .flt_wen(flt_wen), .flt_wdata(flt_wdata),
    .done1(done1), .done2(done2), .busy(busy), .abort(abort)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(a * 16'd40503) ^ 16'h5A5A;
  endfunction

  // Source memory: data valid one cycle after the read.
  always @(posedge clk) mem_rdata <= mem_ren ? memf(mem_addr) : 16'hDEAD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: strict IF/FLT alternation while both have words left, otherwise
  // whichever stream remains; cut stops before filter beat number 'cut'.
  task automatic plan(input logic [AW-1:0] ib, input int il, input logic [AW-1:0] fb,
                      input int fl, input int cut, output int ni, output int nf);
    int    i, j;
    logic  turn, take_flt;
    beat_t b;
    i = 0; j = 0; turn = 1'b0;
    while (i < il || j < fl) begin
      take_flt = (i < il && j < fl) ? turn : (j < fl);
      if (take_flt && j == cut) break;
      if (take_flt) begin
        b.strm = 1'b1; b.addr = AW'(int'(fb) + j); j++; b.last = (j == fl);
      end else begin
        b.strm = 1'b0; b.addr = AW'(int'(ib) + i); i++; b.last = (i == il);
      end
      rd_q.push_back(b);
      wr_q.push_back(b);
      turn = ~turn;
    end
    ni = i; nf = j;
  endtask

  // Monitor: pops expectations whenever the DUT reads or writes.
  initial begin
    logic       prev_ren;
    logic [1:0] done_due;
    beat_t      b;
    prev_ren = 1'b0; done_due = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_ren = 1'b0; done_due = '0;
      end else begin
        if (done_due[0]) chk("done1_rise", 64'(done1), 64'd1);
        if (done_due[1]) chk("done2_rise", 64'(done2), 64'd1);
        done_due = '0;
        if (prev_ren || if_wen || flt_wen) begin
          chk("wr_after_rd", 64'(if_wen | flt_wen), 64'(prev_ren));
          chk("one_wen", 64'(if_wen & flt_wen), 64'd0);
        end
        if (if_wen || flt_wen) begin
          if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
          else begin
            b = wr_q.pop_front();
            chk("wr_strm", 64'(flt_wen), 64'(b.strm));
            chk("wr_data", 64'(flt_wen ? flt_wdata : if_wdata), 64'(memf(b.addr)));
            if (b.last) begin
              chk("done_before_last", 64'(b.strm ? done2 : done1), 64'd0);
              done_due[b.strm] = 1'b1;
            end
          end
        end
        if (mem_ren) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
          else begin
            b = rd_q.pop_front();
            chk("rd_addr", 64'(mem_addr), 64'(b.addr));
          end
        end
        prev_ren = mem_ren;
      end
    end
  end

  // mode 0: plain fill, 1: flt_full before 2nd filter beat, 2: ignored start mid-fill
  task automatic run_fill(input logic [AW-1:0] ib, input logic [LW-1:0] il,
                          input logic [AW-1:0] fb, input logic [LW-1:0] fl, input int mode);
    int   ni, nf, n_abort, lim;
    logic seen;
    plan(ib, int'(il), fb, int'(fl), (mode == 1) ? 1 : -1, ni, nf);
    if_full  = (il == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    flt_full = (fl == 0 && mode != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    if_base = ib; if_len = il; flt_base = fb; flt_len = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done1_init", 64'(done1), 64'(il == 0));
    chk("done2_init", 64'(done2), 64'(fl == 0));
    chk("busy_start", 64'(busy), 64'd1);
    n_abort = 0;
    if (mode == 2) begin
      repeat (2) @(negedge clk);
      if_base = ~ib; flt_base = ~fb; if_len = il + 8'd3; flt_len = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (abort) n_abort++;
    end
    if (mode == 1) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (mem_ren && mem_addr == fb) seen = 1'b1;
      end
      chk("flt_rd_seen", 64'(seen), 64'd1);
      flt_full = 1'b1;
    end
    lim = 2 * (int'(il) + int'(fl)) + 20;
    while (busy && lim > 0) begin
      @(negedge clk);
      if (abort) n_abort++;
      lim--;
    end
    chk("fill_ends", 64'(busy), 64'd0);
    chk("abort_cnt", 64'(n_abort), 64'(mode == 1));
    chk("done1_end", 64'(done1), 64'(ni == int'(il)));
    chk("done2_end", 64'(done2), 64'(nf == int'(fl)));
    @(negedge clk);
    chk("abort_pulse", 64'(abort), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    if_full = 1'b0; flt_full = 1'b0;
  endtask

  initial begin
    int            ni, nf, nrd;
    logic [LW-1:0] il, fl;
    logic [AW-1:0] ib, fb;
    int            mode;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'({mem_ren, if_wen, flt_wen, done1, done2, busy, abort,
                          mem_addr, if_wdata, flt_wdata}), 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 64'(busy), 64'd0);

    run_fill(16'h0100, 8'd4, 16'h0200, 8'd3, 0);
    run_fill(16'h0100, 8'd0, 16'h0200, 8'd2, 0);
    run_fill(16'h0100, 8'd4, 16'h0200, 8'd4, 1);
    run_fill(16'h0100, 8'd5, 16'h0200, 8'd5, 2);

    // Asynchronous reset with a write in flight.
    plan(16'h0300, 6, 16'h0400, 6, -1, ni, nf);
    @(negedge clk);
    if_base = 16'h0300; if_len = 8'd6; flt_base = 16'h0400; flt_len = 8'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nrd = 0;
    for (int k = 0; k < 30 && nrd < 3; k++) begin
      @(negedge clk);
      if (mem_ren) nrd++;
    end
    chk("rd_before_rst", 64'(nrd), 64'd3);
    #2 rst = 1'b0;
    #1 chk("rst_mid_fill", 64'({mem_ren, if_wen, flt_wen, done1, done2, busy, abort,
                               mem_addr, if_wdata, flt_wdata}), 64'd0);
    rd_q.delete(); wr_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_post_rst", 64'(busy), 64'd0);
    run_fill(16'h0300, 8'd3, 16'h0400, 8'd2, 0);

    run_fill(16'hFFFF, 8'd2, 16'h0200, 8'd1, 0);
    run_fill(16'h0000, 8'd0, 16'h0000, 8'd0, 0);
    run_fill(16'hFF00, 8'd255, 16'h0010, 8'd255, 0);

    for (int t = 0; t < 30; t++) begin
      il = 8'($urandom_range(0, 12));
      fl = 8'($urandom_range(0, 12));
      ib = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
      mode = (int'(il) + int'(fl) >= 6 && $urandom_range(0, 2) == 0) ? 2 : 0;
      run_fill(ib, il, fb, fl, mode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
